// File: rtl/memspx_arb_if.sv
// Two-port RAM arbiter bus bundle: port A/B command and return signals plus the RAM-side command/data.
// slave = arbiter view, master = requesters + RAM view.
interface memspx_arb_if #(
    parameter int ADDRBIT = 11,
    parameter int WIDTH   = 32
);
    logic               a_req;
    logic               a_we;
    logic [ADDRBIT-1:0] a_addr;
    logic [WIDTH-1:0]   a_di;
    logic               a_gnt;
    logic               a_rvld;

    logic               b_req;
    logic               b_we;
    logic [ADDRBIT-1:0] b_addr;
    logic [WIDTH-1:0]   b_di;
    logic               b_gnt;
    logic               b_rvld;

    logic [WIDTH-1:0]   r_do;

    logic [ADDRBIT-1:0] m_a;
    logic               m_we;
    logic [WIDTH-1:0]   m_di;
    logic [WIDTH-1:0]   m_do;

    modport slave (
        input  a_req, a_we, a_addr, a_di,
        input  b_req, b_we, b_addr, b_di,
        input  m_do,
        output a_gnt, a_rvld, b_gnt, b_rvld,
        output r_do, m_a, m_we, m_di
    );

    modport master (
        output a_req, a_we, a_addr, a_di,
        output b_req, b_we, b_addr, b_di,
        output m_do,
        input  a_gnt, a_rvld, b_gnt, b_rvld,
        input  r_do, m_a, m_we, m_di
    );
endinterface

// File: rtl/memspx_arb.sv
// Two-port arbiter onto one single-port RAM; round-robin, or A-fixed priority with MEMSPX_ARB_FIXPRI_EN.
// Latency: grant and RAM command combinational; read return rvld RDLAT cycles after the grant.
// Backpressure: a requester holds its command until gnt; returns cannot be stalled.
module memspx_arb #(
    parameter int ADDRBIT = 11,
    parameter int WIDTH   = 32,
    parameter int RDLAT   = 3
) (
    input  logic         clk,
    input  logic         rst_,
    memspx_arb_if.slave  bus
);

    logic               a_gnt;
    logic               b_gnt;
    logic [ADDRBIT-1:0] cmd_a;
    logic               cmd_we;
    logic [WIDTH-1:0]   cmd_di;

`ifdef MEMSPX_ARB_FIXPRI_EN
    always_comb begin
        a_gnt = bus.a_req;
        b_gnt = bus.b_req & ~bus.a_req;
    end
`else
    // last_b_q = 1 means B was granted most recently, so A wins the next tie.
    logic last_b_q;
    logic last_b_d;

    always_comb begin
        a_gnt    = bus.a_req & (~bus.b_req | last_b_q);
        b_gnt    = bus.b_req & (~bus.a_req | ~last_b_q);
        last_b_d = last_b_q;
        if (a_gnt | b_gnt) begin
            last_b_d = b_gnt;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end
`endif

    always_comb begin
        cmd_a  = '0;
        cmd_we = 1'b0;
        cmd_di = '0;
        if (a_gnt) begin
            cmd_a  = bus.a_addr;
            cmd_we = bus.a_we;
            cmd_di = bus.a_di;
        end else if (b_gnt) begin
            cmd_a  = bus.b_addr;
            cmd_we = bus.b_we;
            cmd_di = bus.b_di;
        end
    end

    // Tag shift register tracks which port owns each read in flight in the RAM.
    logic [RDLAT-1:0] tag_vld_q;
    logic [RDLAT-1:0] tag_vld_d;
    logic [RDLAT-1:0] tag_port_q;
    logic [RDLAT-1:0] tag_port_d;

    always_comb begin
        tag_vld_d     = tag_vld_q << 1;
        tag_port_d    = tag_port_q << 1;
        tag_vld_d[0]  = (a_gnt | b_gnt) & ~cmd_we;
        tag_port_d[0] = b_gnt;
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            tag_vld_q  <= '0;
            tag_port_q <= '0;
        end else begin
            tag_vld_q  <= tag_vld_d;
            tag_port_q <= tag_port_d;
        end
    end

    assign bus.a_gnt  = a_gnt;
    assign bus.b_gnt  = b_gnt;
    assign bus.m_a    = cmd_a;
    assign bus.m_we   = cmd_we;
    assign bus.m_di   = cmd_di;
    assign bus.a_rvld = tag_vld_q[RDLAT-1] & ~tag_port_q[RDLAT-1];
    assign bus.b_rvld = tag_vld_q[RDLAT-1] &  tag_port_q[RDLAT-1];
    assign bus.r_do   = bus.m_do;

endmodule

// File: tb/tb_memspx_arb.sv
// Bench for memspx_arb: RAM model, queue-based return model, grant table and directed corner cases.
// Build with MEMSPX_ARB_FIXPRI_EN defined to check the fixed-priority variant.
module tb_memspx_arb;
    localparam int ADDRBIT = 11;
    localparam int WIDTH   = 32;
    localparam int RDLAT   = 3;
    localparam int NWORDS  = 1 << ADDRBIT;

    logic clk  = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    memspx_arb_if #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) bus ();

    memspx_arb #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH), .RDLAT(RDLAT)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus.slave)
    );

    // RAM: in-order, read data appears RDLAT cycles after the command, read-before-write.
    logic [WIDTH-1:0] ram     [NWORDS];
    logic [WIDTH-1:0] rd_pipe [RDLAT];
    always_ff @(posedge clk) begin
        if (bus.m_we) ram[bus.m_a] <= bus.m_di;
        rd_pipe[0] <= ram[bus.m_a];
        for (int i = 1; i < RDLAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.m_do = rd_pipe[RDLAT-1];

    typedef struct {
        int               due;
        bit               port;
        logic [WIDTH-1:0] data;
    } rd_t;

    rd_t              exp_q[$];
    logic [WIDTH-1:0] ref_mem [NWORDS];
    int               cyc;
    int               n_tests;
    int               n_fail;
    bit               last_ga;
    bit               last_gb;
`ifndef MEMSPX_ARB_FIXPRI_EN
    bit               m_last_b;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Called at posedge+1 with inputs applied; checks mid-cycle, updates the model, advances one cycle.
    task automatic tick(input bit use_tbl, input bit ea, input bit eb);
        bit               ga, gb, ea_rv, eb_rv;
        logic [ADDRBIT-1:0] e_a;
        logic             e_we;
        logic [WIDTH-1:0] e_di, e_rd;
        #3;
        if (!rst_) begin
            exp_q.delete();
`ifndef MEMSPX_ARB_FIXPRI_EN
            m_last_b = 1'b1;
`endif
        end
`ifdef MEMSPX_ARB_FIXPRI_EN
        ga = bus.a_req;
        gb = bus.b_req && !bus.a_req;
`else
        if (bus.a_req && bus.b_req) begin
            ga = m_last_b;
            gb = !m_last_b;
        end else begin
            ga = bus.a_req;
            gb = bus.b_req;
        end
`endif
        e_a = '0; e_we = 1'b0; e_di = '0;
        if (ga) begin e_a = bus.a_addr; e_we = bus.a_we; e_di = bus.a_di; end
        if (gb) begin e_a = bus.b_addr; e_we = bus.b_we; e_di = bus.b_di; end
        ea_rv = 1'b0; eb_rv = 1'b0; e_rd = '0;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            if (exp_q[0].port) eb_rv = 1'b1; else ea_rv = 1'b1;
            e_rd = exp_q[0].data;
            void'(exp_q.pop_front());
        end
        chk("a_gnt", bus.a_gnt, ga);
        chk("b_gnt", bus.b_gnt, gb);
        chk("m_a", bus.m_a, e_a);
        chk("m_we", bus.m_we, e_we);
        chk("m_di", bus.m_di, e_di);
        chk("a_rvld", bus.a_rvld, ea_rv);
        chk("b_rvld", bus.b_rvld, eb_rv);
        if (ea_rv || eb_rv) chk("r_do", bus.r_do, e_rd);
        if (use_tbl) begin
            chk("tbl_a_gnt", bus.a_gnt, ea);
            chk("tbl_b_gnt", bus.b_gnt, eb);
        end
        if (ga || gb) begin
            if (!e_we && rst_) exp_q.push_back('{due: cyc + RDLAT, port: gb, data: ref_mem[e_a]});
            if (e_we) ref_mem[e_a] = e_di;
`ifndef MEMSPX_ARB_FIXPRI_EN
            if (rst_) m_last_b = gb;
`endif
        end
        last_ga = ga;
        last_gb = gb;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        rst_ = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        rst_ = 1'b1;
    endtask

    typedef struct {
        bit a_req, b_req;
        bit ea_rr, eb_rr, ea_fp, eb_fp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        bit ta, tb;
        n_tests = 0; n_fail = 0; cyc = 0;
        last_ga = 1'b0; last_gb = 1'b0;
`ifndef MEMSPX_ARB_FIXPRI_EN
        m_last_b = 1'b1;
`endif
        for (int i = 0; i < NWORDS; i++) ref_mem[i] = '0;
        bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_di = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_di = '0;

        // Reset state, with requests idle.
        @(posedge clk); #1;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        rst_ = 1'b1;

        // Grant sequence from the reset pointer (B last).
        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 0, 1, 0, 1, 0};
        tbl[2] = '{1, 1, 0, 1, 1, 0};
        tbl[3] = '{1, 1, 1, 0, 1, 0};
        tbl[4] = '{0, 1, 0, 1, 0, 1};
        tbl[5] = '{0, 1, 0, 1, 0, 1};
        tbl[6] = '{1, 1, 1, 0, 1, 0};
        tbl[7] = '{1, 0, 1, 0, 1, 0};
        tbl[8] = '{1, 1, 0, 1, 1, 0};
        tbl[9] = '{0, 0, 0, 0, 0, 0};
        bus.a_we = 1'b1; bus.a_addr = 11'h003; bus.a_di = 32'hA000_0003;
        bus.b_we = 1'b1; bus.b_addr = 11'h004; bus.b_di = 32'hB000_0004;
        for (int i = 0; i < 10; i++) begin
            bus.a_req = tbl[i].a_req;
            bus.b_req = tbl[i].b_req;
`ifdef MEMSPX_ARB_FIXPRI_EN
            ta = tbl[i].ea_fp; tb = tbl[i].eb_fp;
`else
            ta = tbl[i].ea_rr; tb = tbl[i].eb_rr;
`endif
            tick(1'b1, ta, tb);
        end
        bus.b_req = 1'b0;

        // Preload addresses 0..15 through port A.
        for (int i = 0; i < 16; i++) begin
            bus.a_req = 1'b1; bus.a_we = 1'b1;
            bus.a_addr = ADDRBIT'(i); bus.a_di = WIDTH'($urandom);
            tick(1'b1, 1'b1, 1'b0);
        end
        idle(1);

        // Single read of 0x005 holding 0xDEADBEEF.
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h005; bus.b_di = 32'hDEAD_BEEF;
        tick(1'b1, 1'b0, 1'b1);
        idle(1);
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h005;
        tick(1'b1, 1'b1, 1'b0);
        idle(2);
        chk("single_a_rvld", bus.a_rvld, 1'b1);
        chk("single_r_do", bus.r_do, 32'hDEAD_BEEF);
        chk("single_b_rvld", bus.b_rvld, 1'b0);
        idle(2);

        // Contention after reset: six cycles of reads from both ports.
        do_reset();
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h001;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 11'h002;
        for (int i = 0; i < 6; i++) begin
`ifdef MEMSPX_ARB_FIXPRI_EN
            tick(1'b1, 1'b1, 1'b0);
`else
            tick(1'b1, (i % 2) == 0, (i % 2) == 1);
`endif
        end
        idle(RDLAT + 2);

        // Write then read of 0x7FF from the other port.
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h7FF; bus.b_di = 32'h1234_5678;
        tick(1'b1, 1'b0, 1'b1);
        bus.b_req = 1'b0;
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h7FF;
        tick(1'b1, 1'b1, 1'b0);
        idle(2);
        chk("wr_rd_a_rvld", bus.a_rvld, 1'b1);
        chk("wr_rd_r_do", bus.r_do, 32'h1234_5678);
        chk("wr_rd_b_rvld", bus.b_rvld, 1'b0);
        idle(2);

        // Read followed by a write to the same address returns the old data.
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h7FF;
        tick(1'b1, 1'b1, 1'b0);
        bus.a_req = 1'b0;
        bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 11'h7FF; bus.b_di = 32'hCAFE_F00D;
        tick(1'b1, 1'b0, 1'b1);
        idle(1);
        chk("raw_a_rvld", bus.a_rvld, 1'b1);
        chk("raw_r_do", bus.r_do, 32'h1234_5678);
        idle(2);

        // Reset one cycle after a granted read drops the read; A wins the next tie.
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h001;
        tick(1'b1, 1'b1, 1'b0);
        do_reset();
        for (int i = 0; i < RDLAT + 2; i++) begin
            chk("rst_drop_a_rvld", bus.a_rvld, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
        end
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h002;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 11'h003;
        tick(1'b1, 1'b1, 1'b0);
        idle(RDLAT + 2);

`ifdef MEMSPX_ARB_FIXPRI_EN
        // Fixed priority: A takes all four tie cycles, B goes as soon as A drops.
        bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 11'h004;
        bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 11'h005;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b1, 1'b0);
        bus.a_req = 1'b0;
        tick(1'b1, 1'b0, 1'b1);
        idle(RDLAT + 2);
`endif

        // Idle: RAM command forced to zero, no returns.
        idle(RDLAT + 1);
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 1'b0, 1'b0);
            chk("idle_m_we", bus.m_we, 1'b0);
        end

        // Random traffic on addresses 0..15 with the hold-until-grant rule.
        for (int n = 0; n < 400; n++) begin
            if (!bus.a_req && $urandom_range(0, 1) == 1) begin
                bus.a_req = 1'b1; bus.a_we = 1'($urandom_range(0, 1));
                bus.a_addr = ADDRBIT'($urandom_range(0, 15)); bus.a_di = WIDTH'($urandom);
            end
            if (!bus.b_req && $urandom_range(0, 1) == 1) begin
                bus.b_req = 1'b1; bus.b_we = 1'($urandom_range(0, 1));
                bus.b_addr = ADDRBIT'($urandom_range(0, 15)); bus.b_di = WIDTH'($urandom);
            end
            tick(1'b0, 1'b0, 1'b0);
            if (last_ga) bus.a_req = 1'b0;
            if (last_gb) bus.b_req = 1'b0;
        end
        idle(RDLAT + 2);
        chk("drained_queue", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
